// File: rtl/cyx_dmem.sv
// cyx_dmem: parametrised data memory for the nanoMIPS load/store path.
// Combinational reads, clocked read-modify-write stores, byte/half/word
// lanes with sign/zero extension, and a hardware clear sequence after reset.
// Optional feature macro: CYX_DMEM_FAULT_EN (sticky misalign/range monitor).

module cyx_dmem_lane (
  input  logic       be,
  input  logic [7:0] wd,
  input  logic [7:0] old,
  output logic [7:0] q
);
  // Byte merge: take the store byte only where the lane is enabled.
  always_comb q = be ? wd : old;
endmodule

module cyx_dmem #(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Adr,
  input  logic [31:0] DIN,
  input  logic        WrEn,
  input  logic        RdEn,
  input  logic [1:0]  Size,
  input  logic        SignExt,
  output logic [31:0] DOUT,
  output logic        Busy,
  output logic        Fault,
  output logic [31:0] FaultAdr
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] LAST = '1;

  typedef enum logic {CLR, READY} state_t;

  state_t                state, state_nx;
  logic [DEPTH_LOG2-1:0] cnt;
  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0]           mem [DEPTH];
  logic [3:0][7:0]       rword;
  logic [3:0][7:0]       wdat;
  logic [3:0][7:0]       merged;
  logic [3:0]            be;
  logic [31:0]           rd_ext;
  logic [7:0]            bsel;
  logic [15:0]           hsel;
  logic                  flt, wr_ok, rd_ok;

  assign idx   = Adr[DEPTH_LOG2+1:2];
  assign Busy  = (state == CLR);
  assign rword = mem[idx];

`ifdef CYX_DMEM_FAULT_EN
  logic misal, oor, acc;
  assign misal = ((Size == 2'b01) && Adr[0]) || (Size[1] && (Adr[1:0] != 2'b00));
  assign oor   = |(Adr >> (DEPTH_LOG2 + 2));
  assign acc   = (WrEn | RdEn) & ~Busy;
  assign flt   = acc & (misal | oor);

  // Sticky fault flag; the address of the first faulting access is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Fault    <= 1'b0;
      FaultAdr <= '0;
    end else if (flt && !Fault) begin
      Fault    <= 1'b1;
      FaultAdr <= Adr;
    end
  end
`else
  // Upper address bits are don't-care: addresses wrap modulo the memory size.
  logic unused_adr;
  assign unused_adr = ^Adr[31:DEPTH_LOG2+2];
  assign flt        = 1'b0;
  assign Fault      = 1'b0;
  assign FaultAdr   = '0;
`endif

  assign wr_ok = WrEn & ~Busy & ~flt;
  assign rd_ok = RdEn & ~Busy & ~flt;

  // Clear state register and clear counter; counter parks on the last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLR;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == CLR && cnt != LAST) cnt <= cnt + 1'b1;
    end
  end

  // Leave CLR on the edge that clears the last word.
  always_comb begin
    state_nx = state;
    if (state == CLR && cnt == LAST) state_nx = READY;
  end

  // Lane enables and right-aligned store data replicated into every lane;
  // misaligned halves/words are force-aligned by ignoring the low bits.
  always_comb begin
    be   = 4'b1111;
    wdat = DIN;
    case (Size)
      2'b00: begin
        be   = 4'b0001 << Adr[1:0];
        wdat = {4{DIN[7:0]}};
      end
      2'b01: begin
        be   = Adr[1] ? 4'b1100 : 4'b0011;
        wdat = {2{DIN[15:0]}};
      end
      default: ;
    endcase
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    cyx_dmem_lane u_lane (
      .be  (be[i]),
      .wd  (wdat[i]),
      .old (rword[i]),
      .q   (merged[i])
    );
  end

  // Memory: the clear sequence owns the write port while busy.
  always_ff @(posedge clk) begin
    if (Busy)       mem[cnt] <= '0;
    else if (wr_ok) mem[idx] <= merged;
  end

  // Load extraction and extension from the pre-write word.
  always_comb begin
    bsel   = rword[Adr[1:0]];
    hsel   = Adr[1] ? {rword[3], rword[2]} : {rword[1], rword[0]};
    rd_ext = rword;
    case (Size)
      2'b00:   rd_ext = {{24{SignExt & bsel[7]}}, bsel};
      2'b01:   rd_ext = {{16{SignExt & hsel[15]}}, hsel};
      default: ;
    endcase
    DOUT = rd_ok ? rd_ext : 32'h0;
  end
endmodule

// File: tb/tb_cyx_dmem.sv
// Self-checking bench for cyx_dmem (DEPTH_LOG2 = 6): directed vector table,
// random traffic against a byte-array model, clear/reset corner cases.
module tb_cyx_dmem;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] Adr, DIN;
  logic        WrEn, RdEn, SignExt;
  logic [1:0]  Size;
  logic [31:0] DOUT, FaultAdr;
  logic        Busy, Fault;

  int ncmp = 0;
  int nbad = 0;
  logic [7:0] mb [256];

  cyx_dmem #(.DEPTH_LOG2(6)) dut (
    .clk(clk), .rst_n(rst_n), .Adr(Adr), .DIN(DIN), .WrEn(WrEn), .RdEn(RdEn),
    .Size(Size), .SignExt(SignExt), .DOUT(DOUT), .Busy(Busy), .Fault(Fault),
    .FaultAdr(FaultAdr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we, re;
    logic [31:0] adr, din;
    logic [1:0]  size;
    logic        sx;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic we, input logic re, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] sz, input logic sx);
    WrEn = we; RdEn = re; Adr = a; DIN = d; Size = sz; SignExt = sx;
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  // Model read: gather little-endian bytes from the aligned base, then extend.
  function automatic logic [31:0] mrd(input logic [31:0] a, input logic [1:0] sz, input logic sx);
    int n = nbytes(sz);
    int base = int'(a & 32'hFF) & ~(n - 1);
    logic [31:0] v = 0;
    for (int i = 0; i < n; i++) v = v | (32'(mb[base + i]) << (8 * i));
    if (sx && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic mwr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    int n = nbytes(sz);
    int base = int'(a & 32'hFF) & ~(n - 1);
    for (int i = 0; i < n; i++) mb[base + i] = d[8 * i +: 8];
  endtask

  task automatic mclear();
    for (int i = 0; i < 256; i++) mb[i] = 8'h00;
  endtask

  // Count edges until Busy drops, bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (Busy && n < 300) begin
      step();
      n++;
    end
  endtask

  vec_t tv [18];
  int   nb;
  logic [31:0] e, ra;
  logic [1:0]  rs;

  initial begin
    tv[0]  = '{1, 0, 32'h08, 32'h11223344, 2'd2, 0, 32'h0};
    tv[1]  = '{1, 0, 32'h09, 32'h000000AB, 2'd0, 0, 32'h0};
    tv[2]  = '{0, 1, 32'h08, 32'h0,        2'd2, 0, 32'h1122AB44};
    tv[3]  = '{0, 1, 32'h09, 32'h0,        2'd0, 1, 32'hFFFFFFAB};
    tv[4]  = '{0, 1, 32'h09, 32'h0,        2'd0, 0, 32'h000000AB};
    tv[5]  = '{0, 1, 32'h08, 32'h0,        2'd1, 1, 32'hFFFFAB44};
    tv[6]  = '{0, 0, 32'h08, 32'h0,        2'd2, 0, 32'h0};
    tv[7]  = '{1, 0, 32'h0C, 32'h55667788, 2'd2, 0, 32'h0};
    tv[8]  = '{1, 0, 32'h0E, 32'h00008001, 2'd1, 0, 32'h0};
    tv[9]  = '{0, 1, 32'h0E, 32'h0,        2'd1, 1, 32'hFFFF8001};
    tv[10] = '{0, 1, 32'h0E, 32'h0,        2'd1, 0, 32'h00008001};
    tv[11] = '{0, 1, 32'h0C, 32'h0,        2'd2, 0, 32'h80017788};
    tv[12] = '{1, 0, 32'h04, 32'h00000005, 2'd2, 0, 32'h0};
    tv[13] = '{1, 1, 32'h04, 32'hDEADBEEF, 2'd2, 0, 32'h00000005};
    tv[14] = '{0, 1, 32'h04, 32'h0,        2'd2, 0, 32'hDEADBEEF};
    tv[15] = '{1, 0, 32'hFC, 32'hA5A5C3C3, 2'd3, 0, 32'h0};
    tv[16] = '{0, 1, 32'hFF, 32'h0,        2'd0, 1, 32'hFFFFFFA5};
    tv[17] = '{0, 1, 32'hFC, 32'h0,        2'd3, 0, 32'hA5A5C3C3};

    drive(0, 1, 32'h8, 32'h0, 2'd2, 0);
    rst_n = 1'b0;
    mclear();
    #12;
    chk("reset_busy", {31'b0, Busy}, 32'h1);
    chk("reset_dout", DOUT, 32'h0);
    chk("reset_fault", {31'b0, Fault}, 32'h0);
    chk("reset_faultadr", FaultAdr, 32'h0);
    step();
    rst_n = 1'b1;
    count_busy(nb);
    chk("clear_edges", nb, 64);

    for (int w = 0; w < 64; w++) begin
      drive(0, 1, 32'(w * 4), 32'h0, 2'd2, 0);
      #1 chk("zero_after_clear", DOUT, 32'h0);
    end

    for (int i = 0; i < 18; i++) begin
      drive(tv[i].we, tv[i].re, tv[i].adr, tv[i].din, tv[i].size, tv[i].sx);
      #1 chk($sformatf("vec%0d", i), DOUT, tv[i].exp);
      if (tv[i].we) mwr(tv[i].adr, tv[i].din, tv[i].size);
      step();
    end

    for (int k = 0; k < 400; k++) begin
      rs = 2'($urandom_range(0, 3));
`ifdef CYX_DMEM_FAULT_EN
      ra = 32'($urandom_range(0, 255)) & ~32'(nbytes(rs) - 1);
`else
      ra = $urandom;
`endif
      drive(1'($urandom), 1'($urandom), ra, $urandom, rs, 1'($urandom));
      e = RdEn ? mrd(ra, rs, SignExt) : 32'h0;
      #1 chk("random_read", DOUT, e);
      if (WrEn) mwr(ra, DIN, rs);
      step();
    end
    chk("random_no_fault", {31'b0, Fault}, 32'h0);

`ifdef CYX_DMEM_FAULT_EN
    e = mrd(32'h4, 2'd2, 0);
    drive(1, 0, 32'h6, 32'hCAFEF00D, 2'd2, 0);
    step();
    chk("fault_set", {31'b0, Fault}, 32'h1);
    chk("fault_adr", FaultAdr, 32'h6);
    drive(0, 1, 32'h4, 32'h0, 2'd2, 0);
    #1 chk("fault_no_write", DOUT, e);
    drive(0, 1, 32'h400, 32'h0, 2'd2, 0);
    #1 chk("fault_oor_dout", DOUT, 32'h0);
    step();
    chk("fault_sticky", {31'b0, Fault}, 32'h1);
    chk("fault_adr_kept", FaultAdr, 32'h6);
`else
    drive(1, 0, 32'h6, 32'hCAFEF00D, 2'd2, 0);
    step();
    drive(0, 1, 32'h4, 32'h0, 2'd2, 0);
    #1 chk("align_word", DOUT, 32'hCAFEF00D);
    drive(1, 0, 32'h0000_0110, 32'h0BADCAFE, 2'd2, 0);
    step();
    drive(0, 1, 32'h10, 32'h0, 2'd2, 0);
    #1 chk("wrap_addr", DOUT, 32'h0BADCAFE);
    chk("fault_tied", {31'b0, Fault} | FaultAdr, 32'h0);
`endif

    // Reset pulsed part-way through a clear; accesses held during the clear.
    drive(0, 0, 32'h0, 32'h0, 2'd2, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (10) step();
    chk("midclear_busy", {31'b0, Busy}, 32'h1);
    rst_n = 1'b0;
    #2;
    chk("midclear_reset_busy", {31'b0, Busy}, 32'h1);
    chk("midclear_fault", {31'b0, Fault}, 32'h0);
    step();
    rst_n = 1'b1;
    drive(1, 1, 32'hF8, 32'hFFFFFFFF, 2'd2, 0);
    #1 chk("busy_dout", DOUT, 32'h0);
    count_busy(nb);
    drive(0, 0, 32'h0, 32'h0, 2'd2, 0);
    chk("reclear_edges", nb, 64);
    chk("busy_no_fault", {31'b0, Fault}, 32'h0);
    drive(0, 1, 32'h08, 32'h0, 2'd2, 0);
    #1 chk("reclear_word8", DOUT, 32'h0);
    drive(0, 1, 32'hF8, 32'h0, 2'd2, 0);
    #1 chk("busy_no_write", DOUT, 32'h0);
    drive(0, 1, 32'hFC, 32'h0, 2'd2, 0);
    #1 chk("reclear_last", DOUT, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL timeout: got hang expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cyx_dmem.md
# cyx_dmem

Parametrised data memory for the single-cycle nanoMIPS CPU, replacing the fixed 16-word data RAM. It adds a configurable depth, byte/halfword/word accesses with sign or zero extension, and a hardware clear sequence after reset. It also has an optional sticky access-fault monitor. It sits on the CPU's load/store path. Reads are combinational so that loads complete in the same cycle; writes commit on the rising clock edge.

## Interface
- DEPTH_LOG2, default 6: memory holds 2^DEPTH_LOG2 32-bit words (legal range 2..12).
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- Adr  in  32  byte address.
- DIN  in  32  store data, right-aligned (the byte is in DIN[7:0], the halfword in DIN[15:0]).
- WrEn  in  1  store strobe.
- RdEn  in  1  load strobe.
- Size  in  2  access size: 00 byte, 01 halfword, 10 word, 11 treated as word.
- SignExt  in  1  loads: 1 sign-extends, 0 zero-extends (ignored for words).
- DOUT  out  32  load data, extracted and extended.
- Busy  out  1  clear sequence in progress; accesses are ignored.
- Fault  out  1  sticky access fault (only with CYX_DMEM_FAULT_EN).
- FaultAdr  out  32  Adr value captured at the first fault.

## Operation
- Word index is Adr[DEPTH_LOG2+1:2]. Lanes are little-endian:
  - byte lane = Adr[1:0];
  - halfword lane = Adr[1] (low half when 0).
- Clear state machine, states CLR and READY:
  - rst_n low: asynchronously enter CLR, clear counter = 0, Busy = 1, Fault = 0, FaultAdr = 0.
  - In CLR: each rising edge writes 0 to word[counter] and increments the counter. The edge that writes word DEPTH-1 moves the state to READY.
  - READY persists until the next reset.
- Reads are combinational, in READY only:
  - with RdEn = 1, DOUT = the selected lane of the addressed word, extended per SignExt;
  - DOUT = 0 when RdEn = 0, when Busy = 1, or when the access faults.
- Writes, in READY only: at the rising edge with WrEn = 1, only the addressed lane bytes are updated (read-modify-write merge); other bytes are preserved.
- WrEn and RdEn both high: DOUT shows the pre-write content during the cycle; the write commits at the edge.
- WrEn/RdEn while Busy: no write, DOUT = 0, no fault recorded.
- Reset asserted during the clear sequence or during normal operation: the counter restarts at 0 and all contents are re-cleared.

## Timing
- Read latency is 0 cycles (combinational from Adr/Size/SignExt/RdEn). Write data is visible on DOUT in the cycle after its edge.
- Clear sequence:
  - Busy is 1 from reset assertion through the DEPTH-th rising edge after rst_n deasserts.
  - Busy drops after that edge, so the first accepted access is at edge DEPTH+1.
- Reset values: DOUT 0, Busy 1, Fault 0, FaultAdr 0, state CLR, counter 0.
- Counter width is DEPTH_LOG2. It never wraps, because the state machine leaves CLR at the edge that writes DEPTH-1.
- Fault and FaultAdr update at the rising edge of the first faulting cycle. Later faults do not change FaultAdr.

## Configuration
- CYX_DMEM_FAULT_EN defined:
  - An access (WrEn or RdEn high, Busy low) faults if it is misaligned or out of range.
    - Misaligned: halfword with Adr[0] = 1, or word with Adr[1:0] != 0.
    - Out of range: Adr[31:DEPTH_LOG2+2] != 0.
  - A faulting access has its write suppressed and DOUT forced to 0. It sets the sticky Fault and captures FaultAdr if Fault was 0.
  - Fault clears only on reset.
- CYX_DMEM_FAULT_EN undefined:
  - Upper address bits are ignored, so addresses wrap modulo 4·DEPTH.
  - Misaligned addresses are force-aligned: Adr[0] is ignored for halfwords, and Adr[1:0] are ignored for words.
  - Fault and FaultAdr are tied to 0.

## Test plan
- Reset release with DEPTH_LOG2 = 6 -> Busy is high for exactly 64 edges; afterwards every word reads 0x00000000.
- Word store 0x11223344 at 0x8, then byte store 0xAB at 0x9 -> word read at 0x8 returns 0x1122AB44. Signed byte read at 0x9 returns 0xFFFFFFAB; unsigned returns 0x000000AB.
- Halfword store 0x8001 at 0xE, then halfword read at 0xE -> SignExt=1 returns 0xFFFF8001; SignExt=0 returns 0x00008001. Word 0xC keeps its low half.
- Simultaneous WrEn/RdEn to 0x4 storing 0xDEADBEEF over 0x5 -> DOUT shows 0x00000005 during the cycle and 0xDEADBEEF in the next cycle.
- Reset pulsed at clear-counter 10 -> the clear restarts from 0, Busy stays high for 64 edges after release, and a previously written word reads 0.
- With CYX_DMEM_FAULT_EN: word store to 0x6, then a read at 0x400 -> no memory change, DOUT 0, Fault 1, FaultAdr 0x00000006 (the second fault does not overwrite it). Without the macro: the same store writes word 0x4.
